// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the RV32I decode stage.
// The stage owns the slave side; the producer/consumer pair owns master.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_alu_op;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_alu_src_imm;
  logic            out_use_pc;
  logic            out_reg_we;
  logic            out_mem_re;
  logic            out_mem_we;
  logic [2:0]      out_mem_size;
  logic            out_branch;
  logic            out_jump;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc,
    output out_ready,
    input  in_ready, out_valid,
    input  out_pc, out_alu_op,
    input  out_rs1, out_rs2, out_rd,
    input  out_imm, out_alu_src_imm,
    input  out_use_pc, out_reg_we,
    input  out_mem_re, out_mem_we,
    input  out_mem_size, out_branch,
    input  out_jump, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  out_ready,
    output in_ready, out_valid,
    output out_pc, out_alu_op,
    output out_rs1, out_rs2, out_rd,
    output out_imm, out_alu_src_imm,
    output out_use_pc, out_reg_we,
    output out_mem_re, out_mem_we,
    output out_mem_size, out_branch,
    output out_jump, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: registered control bundle,
// 1-cycle latency, 2-entry skid buffer, optional M-extension.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit EN_M_EXT = 1'b0,
  parameter bit EN_SKID  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            alu_src_imm;
    logic            use_pc;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic [2:0]      mem_size;
    logic            branch;
    logic            jump;
    logic            illegal;
  } dec_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign ins = bus.in_instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  logic is_op, is_opimm, is_load, is_store;
  logic is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc;

  assign is_op     = opc == OPC_OP;
  assign is_opimm  = opc == OPC_OPIMM;
  assign is_load   = opc == OPC_LOAD;
  assign is_store  = opc == OPC_STORE;
  assign is_branch = opc == OPC_BRANCH;
  assign is_jal    = opc == OPC_JAL;
  assign is_jalr   = opc == OPC_JALR;
  assign is_lui    = opc == OPC_LUI;
  assign is_auipc  = opc == OPC_AUIPC;

  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] imm_u, imm_j;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25],
                  ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31],
                  ins[19:12], ins[20],
                  ins[30:21], 1'b0};

  dec_t        dec;
  logic [31:0] imm32;

  always_comb begin
    dec     = '0;
    imm32   = '0;
    dec.pc  = bus.in_pc;
    unique case (1'b1)
      is_op: begin
        dec.rs1    = ins[19:15];
        dec.rs2    = ins[24:20];
        dec.rd     = ins[11:7];
        dec.reg_we = 1'b1;
        if (f7 == F7_BASE) begin
          dec.alu_op = {2'b00, f3};
        end else if (f7 == F7_ALT &&
                     (f3 == 3'b000 ||
                      f3 == 3'b101)) begin
          dec.alu_op = {2'b01, f3};
        end else if (f7 == F7_MUL && EN_M_EXT) begin
          dec.alu_op = {2'b10, f3};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      is_opimm: begin
        dec.rs1         = ins[19:15];
        dec.rd          = ins[11:7];
        imm32           = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = 1'b1;
        dec.alu_op      = {1'b0,
                           f3 == 3'b101 && ins[30],
                           f3};
        if (f3 == 3'b001 && f7 != F7_BASE)
          dec.illegal = 1'b1;
        if (f3 == 3'b101 && f7 != F7_BASE &&
            f7 != F7_ALT)
          dec.illegal = 1'b1;
      end
      is_load: begin
        dec.rs1         = ins[19:15];
        dec.rd          = ins[11:7];
        imm32           = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = 1'b1;
        dec.mem_re      = 1'b1;
        dec.mem_size    = f3;
        if (f3 == 3'b011 || f3 == 3'b110 ||
            f3 == 3'b111)
          dec.illegal = 1'b1;
      end
      is_store: begin
        dec.rs1         = ins[19:15];
        dec.rs2         = ins[24:20];
        imm32           = imm_s;
        dec.alu_src_imm = 1'b1;
        dec.mem_we      = 1'b1;
        dec.mem_size    = f3;
        if (f3 > 3'b010)
          dec.illegal = 1'b1;
      end
      is_branch: begin
        dec.rs1    = ins[19:15];
        dec.rs2    = ins[24:20];
        imm32      = imm_b;
        dec.alu_op = 5'b01000;
        dec.branch = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011)
          dec.illegal = 1'b1;
      end
      is_jal: begin
        dec.rd          = ins[11:7];
        imm32           = imm_j;
        dec.alu_src_imm = 1'b1;
        dec.use_pc      = 1'b1;
        dec.reg_we      = 1'b1;
        dec.jump        = 1'b1;
      end
      is_jalr: begin
        dec.rs1         = ins[19:15];
        dec.rd          = ins[11:7];
        imm32           = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = 1'b1;
        dec.jump        = 1'b1;
        if (f3 != 3'b000)
          dec.illegal = 1'b1;
      end
      is_lui: begin
        dec.rd          = ins[11:7];
        imm32           = imm_u;
        dec.alu_src_imm = 1'b1;
        dec.reg_we      = 1'b1;
      end
      is_auipc: begin
        dec.rd          = ins[11:7];
        imm32           = imm_u;
        dec.alu_src_imm = 1'b1;
        dec.use_pc      = 1'b1;
        dec.reg_we      = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    if (dec.illegal || dec.rd == 5'd0)
      dec.reg_we = 1'b0;
    // an illegal bundle must not touch state downstream
    if (dec.illegal) begin
      dec.mem_re = 1'b0;
      dec.mem_we = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
    end
  end

  dec_t out_q;
  dec_t skid_q;
  logic out_vld;
  logic skid_vld;
  logic accept;
  logic load_out;

  assign bus.in_ready = EN_SKID ? ~skid_vld
                        : (bus.out_ready | ~out_vld);
  assign accept   = bus.in_valid & bus.in_ready &
                    ~flush;
  assign load_out = ~out_vld | bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (load_out) begin
      // skid is older than any new input
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_q   <= dec;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  assign bus.out_valid       = out_vld;
  assign bus.out_pc          = out_q.pc;
  assign bus.out_alu_op      = out_q.alu_op;
  assign bus.out_rs1         = out_q.rs1;
  assign bus.out_rs2         = out_q.rs2;
  assign bus.out_rd          = out_q.rd;
  assign bus.out_imm         = out_q.imm;
  assign bus.out_alu_src_imm = out_q.alu_src_imm;
  assign bus.out_use_pc      = out_q.use_pc;
  assign bus.out_reg_we      = out_q.reg_we;
  assign bus.out_mem_re      = out_q.mem_re;
  assign bus.out_mem_we      = out_q.mem_we;
  assign bus.out_mem_size    = out_q.mem_size;
  assign bus.out_branch      = out_q.branch;
  assign bus.out_jump        = out_q.jump;
  assign bus.out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-decoded expected
// bundles queued on accept, compared when the stage issues.
module tb_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src;
    logic        upc;
    logic        we;
    logic        re;
    logic        mwe;
    logic [2:0]  size;
    logic        br;
    logic        jmp;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(
    .XLEN(32), .EN_M_EXT(1'b0), .EN_SKID(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rand_bp = 1'b0;
  exp_t cur;
  exp_t q[$];
  exp_t tbl[13];

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(
    logic [31:0] instr, logic [31:0] pc,
    logic [4:0] alu, logic [4:0] rs1,
    logic [4:0] rs2, logic [4:0] rd,
    logic [31:0] imm, logic src, logic upc,
    logic we, logic re, logic mwe,
    logic [2:0] size, logic br, logic jmp,
    logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.alu = alu;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.src = src; e.upc = upc;
    e.we = we; e.re = re; e.mwe = mwe;
    e.size = size; e.br = br; e.jmp = jmp;
    e.ill = ill;
    return e;
  endfunction

  task automatic compare(exp_t e);
    chk("pc", bus.out_pc, e.pc);
    chk("illegal", bus.out_illegal, e.ill);
    chk("reg_we", bus.out_reg_we, e.we);
    chk("mem_re", bus.out_mem_re, e.re);
    chk("mem_we", bus.out_mem_we, e.mwe);
    chk("branch", bus.out_branch, e.br);
    chk("jump", bus.out_jump, e.jmp);
    if (!e.ill) begin
      chk("alu_op", bus.out_alu_op, e.alu);
      chk("rs1", bus.out_rs1, e.rs1);
      chk("rs2", bus.out_rs2, e.rs2);
      chk("rd", bus.out_rd, e.rd);
      chk("imm", bus.out_imm, e.imm);
      chk("src_imm", bus.out_alu_src_imm, e.src);
      chk("use_pc", bus.out_use_pc, e.upc);
      chk("mem_size", bus.out_mem_size, e.size);
    end
  endtask

  // evaluate one cycle's handshakes, then advance
  task automatic tick(output bit acc);
    exp_t e;
    if (rand_bp)
      bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    acc = bus.in_valid && bus.in_ready && !flush;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        compare(e);
      end
    end
    if (acc) q.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic drive(exp_t e);
    cur          = e;
    bus.in_valid = 1'b1;
    bus.in_instr = e.instr;
    bus.in_pc    = e.pc;
  endtask

  task automatic send(exp_t e, int max_cyc);
    bit a;
    a = 1'b0;
    drive(e);
    for (int i = 0; i < max_cyc && !a; i++)
      tick(a);
    if (!a) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(32'h002081B3, 32'h100, 5'h00,
                 1, 2, 3, 32'h0, 0, 0, 1, 0, 0,
                 3'd0, 0, 0, 0);
    tbl[1]  = mk(32'hFFC12283, 32'h104, 5'h00,
                 2, 0, 5, 32'hFFFFFFFC, 1, 0, 1,
                 1, 0, 3'd2, 0, 0, 0);
    tbl[2]  = mk(32'h403100B3, 32'h108, 5'h08,
                 2, 3, 1, 32'h0, 0, 0, 1, 0, 0,
                 3'd0, 0, 0, 0);
    tbl[3]  = mk(32'h00512423, 32'h10C, 5'h00,
                 2, 5, 0, 32'h8, 1, 0, 0, 0, 1,
                 3'd2, 0, 0, 0);
    tbl[4]  = mk(32'hFE208CE3, 32'h110, 5'h08,
                 1, 2, 0, 32'hFFFFFFF8, 0, 0, 0,
                 0, 0, 3'd0, 1, 0, 0);
    tbl[5]  = mk(32'h123453B7, 32'h114, 5'h00,
                 0, 0, 7, 32'h12345000, 1, 0, 1,
                 0, 0, 3'd0, 0, 0, 0);
    tbl[6]  = mk(32'h010000EF, 32'h118, 5'h00,
                 0, 0, 1, 32'h10, 1, 1, 1, 0, 0,
                 3'd0, 0, 1, 0);
    tbl[7]  = mk(32'h4032D213, 32'h11C, 5'h0D,
                 5, 0, 4, 32'h403, 1, 0, 1, 0, 0,
                 3'd0, 0, 0, 0);
    tbl[8]  = mk(32'h00000000, 32'h120, 5'h00,
                 0, 0, 0, 32'h0, 0, 0, 0, 0, 0,
                 3'd0, 0, 0, 1);
    tbl[9]  = mk(32'h022081B3, 32'h124, 5'h00,
                 0, 0, 0, 32'h0, 0, 0, 0, 0, 0,
                 3'd0, 0, 0, 1);
    tbl[10] = mk(32'h000010E7, 32'h128, 5'h00,
                 0, 0, 0, 32'h0, 0, 0, 0, 0, 0,
                 3'd0, 0, 0, 1);
    tbl[11] = mk(32'h00208033, 32'h12C, 5'h00,
                 1, 2, 0, 32'h0, 0, 0, 0, 0, 0,
                 3'd0, 0, 0, 0);
    tbl[12] = mk(32'h80000517, 32'h130, 5'h00,
                 0, 0, 10, 32'h80000000, 1, 1, 1,
                 0, 0, 3'd0, 0, 0, 0);

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;

    // reset state
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(1);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // full-rate stream, latency 1, every format
    for (int i = 0; i < 13; i++) send(tbl[i], 1);
    idle();
    ticks(2);
    chk("drain1", q.size(), 0);

    // backpressure: output + skid hold, third waits
    bus.out_ready = 1'b0;
    send(tbl[0], 2);
    send(tbl[1], 2);
    drive(tbl[2]);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_pc", bus.out_pc, tbl[0].pc);
      ticks(1);
    end
    bus.out_ready = 1'b1;
    send(tbl[2], 4);
    idle();
    ticks(3);
    chk("drain2", q.size(), 0);

    // flush with both entries full and input valid
    bus.out_ready = 1'b0;
    send(tbl[3], 2);
    send(tbl[4], 2);
    drive(tbl[5]);
    flush = 1'b1;
    ticks(1);
    flush = 1'b0;
    idle();
    q.delete();
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    ticks(2);
    chk("flush_dropped", bus.out_valid, 0);
    send(tbl[6], 1);
    idle();
    ticks(2);
    chk("drain3", q.size(), 0);

    // random backpressure, order and count kept
    rand_bp = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 13; i++)
        send(tbl[i], 20);
    idle();
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    ticks(4);
    chk("drain4", q.size(), 0);

    // async reset mid-stream with both entries full
    bus.out_ready = 1'b0;
    send(tbl[7], 2);
    send(tbl[12], 2);
    drive(tbl[0]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_outs",
        {bus.out_pc, bus.out_alu_op, bus.out_rs1,
         bus.out_rs2, bus.out_rd, bus.out_imm[26:0],
         bus.out_alu_src_imm, bus.out_use_pc,
         bus.out_reg_we, bus.out_mem_re},
        0);
    chk("mid_rst_outs2",
        {bus.out_imm[31:27], bus.out_mem_we,
         bus.out_mem_size, bus.out_branch,
         bus.out_jump, bus.out_illegal},
        0);
    idle();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(tbl[1], 1);
    idle();
    ticks(2);
    chk("drain5", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
